// File: rtl/vga_sync_decoder_if.sv
// Sync input pair and recovered timing outputs between a VGA sync source and the decoder.
// The decoder takes the slave modport; the source/consumer side takes master.
interface vga_sync_decoder_if #(
    parameter int COUNT_W = 10
);
    logic               H_Sync;
    logic               V_Sync;
    logic [COUNT_W-1:0] Col_Count;
    logic [COUNT_W-1:0] Row_Count;
    logic               Active;
    logic               Frame_Start;
    logic               Locked;
    logic               Sync_Err;
    logic [1:0]         Dbg_State;

    modport master (
        output H_Sync, V_Sync,
        input  Col_Count, Row_Count, Active, Frame_Start, Locked, Sync_Err, Dbg_State
    );

    modport slave (
        input  H_Sync, V_Sync,
        output Col_Count, Row_Count, Active, Frame_Start, Locked, Sync_Err, Dbg_State
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers column/row counts from an H_Sync/V_Sync pair and validates them against the
// expected frame geometry, reporting lock, active region, frame start and sync errors.
module vga_sync_decoder #(
    parameter int TOTAL_COLS  = 800,
    parameter int TOTAL_ROWS  = 525,
    parameter int ACTIVE_COLS = 640,
    parameter int ACTIVE_ROWS = 480,
    parameter int LOCK_FRAMES = 2,
    parameter int COUNT_W     = 10
) (
    input  logic              CLK,
    input  logic              RST_N,
    vga_sync_decoder_if.slave sync_if
);
    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int                 GOOD_W    = $clog2(LOCK_FRAMES + 1);
    localparam logic [COUNT_W-1:0] LAST_COL  = COUNT_W'(TOTAL_COLS - 1);
    localparam logic [COUNT_W-1:0] LAST_ROW  = COUNT_W'(TOTAL_ROWS - 1);
    localparam logic [COUNT_W-1:0] ACT_COLS  = COUNT_W'(ACTIVE_COLS);
    localparam logic [COUNT_W-1:0] ACT_ROWS  = COUNT_W'(ACTIVE_ROWS);
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
    localparam logic [GOOD_W-1:0]  GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);

    logic               r_h_q;
    logic               r_v_q;
    logic [COUNT_W-1:0] r_col;
    logic [COUNT_W-1:0] r_row;
    state_t             r_state;
    logic [GOOD_W-1:0]  r_good;
    logic               r_frame_start;
    logic               r_sync_err;
    logic               r_locked;

    logic w_h_rise;
    logic w_v_rise;
    logic w_frame_edge;
    logic w_err;

    assign w_h_rise     = sync_if.H_Sync & ~r_h_q;
    assign w_v_rise     = sync_if.V_Sync & ~r_v_q;
    assign w_frame_edge = w_h_rise & w_v_rise;

    // Errors are judged on the counts before this cycle's update.
    assign w_err = (w_h_rise && (r_col != LAST_COL))
                || (w_frame_edge && (r_row != LAST_ROW))
                || (w_v_rise && !w_h_rise)
                || (!w_h_rise && (r_col == LAST_COL))
                || (w_h_rise && !w_v_rise && (r_row == LAST_ROW));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_h_q <= 1'b1;
            r_v_q <= 1'b1;
            r_col <= '0;
            r_row <= '0;
        end else begin
            r_h_q <= sync_if.H_Sync;
            r_v_q <= sync_if.V_Sync;
            if (w_frame_edge) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_h_rise) begin
                r_col <= '0;
                if (r_row != CNT_MAX) r_row <= r_row + 1'b1;
            end else if (r_col != CNT_MAX) begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // An error on the same cycle as a frame edge drops to SEARCH; re-entry waits for the next edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= SEARCH;
            r_good        <= '0;
            r_frame_start <= 1'b0;
            r_sync_err    <= 1'b0;
            r_locked      <= 1'b0;
        end else begin
            r_frame_start <= w_frame_edge;
            r_sync_err    <= 1'b0;
            case (r_state)
                SEARCH: begin
                    if (w_frame_edge) begin
                        r_state <= ACQUIRE;
                        r_good  <= '0;
                    end
                end
                ACQUIRE: begin
                    if (w_err) begin
                        r_sync_err <= 1'b1;
                        r_state    <= SEARCH;
                        r_locked   <= 1'b0;
                    end else if (w_frame_edge) begin
                        r_good <= r_good + 1'b1;
                        if (r_good == GOOD_LAST) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (w_err) begin
                        r_sync_err <= 1'b1;
                        r_state    <= SEARCH;
                        r_locked   <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign sync_if.Col_Count   = r_col;
    assign sync_if.Row_Count   = r_row;
    assign sync_if.Frame_Start = r_frame_start;
    assign sync_if.Sync_Err    = r_sync_err;
    assign sync_if.Locked      = r_locked;
    assign sync_if.Dbg_State   = r_state;
    assign sync_if.Active      = r_locked && (r_col < ACT_COLS) && (r_row < ACT_ROWS);
endmodule
